ad100_ram_responder: RTL

Word-addressed memory responder on the ad100 CPU data/instruction bus; the target end of the requests the CPU core issues as initiator. Accepts one request at a time over a valid/ready handshake, applies a programmable number of wait states, performs a byte-strobed write or a full-word read on an internal RAM array, and returns a response over a second valid/ready handshake. Sits between the CPU bus port and the on-chip `ram` array in the ad100 top level.

---
 rtl/ad100_ram_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ad100_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ad100_ram_responder
//  Purpose  : ad100 bus target; valid/ready request in, programmable wait
//             states, byte-strobed write / word read of on-chip RAM, response
//             out. Optional macro AD100_RAM_BOUNDS_EN flags req_addr >= DEPTH.
//  Revision : 1.0  initial release
// ============================================================================
module ad100_ram_responder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic       ZERO_WAIT = (WAIT == 0);
    localparam logic [3:0] CNT_LOAD  = 4'((WAIT > 0) ? (WAIT - 1) : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              access_go;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_wstrb;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_oob;
    logic              wr_go;
    logic              unused_addr_bits;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ZERO_WAIT) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_valid && resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are masked by rst so nothing is offered during reset.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        access_go  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = ~rst;
                access_go = ZERO_WAIT & req_valid & ~rst;
            end
            S_WAIT: access_go = (cnt_q == 4'd0) & ~rst;
            S_RESP: resp_valid = ~rst;
            default: ;
        endcase
    end

    assign accept = req_valid & req_ready;

    // ---------------------------------------------------------------- capture
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // With zero wait states the access happens in the accept cycle, so the
    // operands come straight from the request port instead of the capture regs.
    assign acc_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign acc_wstrb = (state_q == S_IDLE) ? req_wstrb : wstrb_q;
    assign acc_idx   = acc_addr[IDX_W-1:0];

    assign unused_addr_bits = ^acc_addr;

`ifdef AD100_RAM_BOUNDS_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    assign acc_oob = ({1'b0, acc_addr} >= DEPTH_LIM);
`else
    assign acc_oob = 1'b0;
`endif

    assign wr_go = access_go & acc_we & ~acc_oob;

    // ---------------------------------------------------------------- RAM
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_go && acc_wstrb[b]) begin
                mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (access_go) begin
            err_q   <= acc_oob;
            rdata_q <= (acc_we || acc_oob) ? 32'd0 : mem[acc_idx];
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire
